// File: rtl/packet_storer_pkg.sv
// packet_storer_pkg
//   Shared definitions for the packet store/load paths: packet geometry,
//   FSM state encodings and the packet-to-word extraction helper.
//   Word 0 is the most significant 32 bits of the packet.
package packet_storer_pkg;

    localparam int PACKET_WIDTH    = 160;
    localparam int WORD_BITS       = 32;
    localparam int WORD_SIZE_BYTES = WORD_BITS / 8;

    typedef enum logic [1:0] {
        S_RECEIVE  = 2'd0,
        S_MEM_SEND = 2'd1,
        S_MEM_ACK  = 2'd2,
        S_DONE     = 2'd3
    } state_e;

    // Word idx of a default-width packet, MSB word first.
    function automatic logic [WORD_BITS-1:0] packet_word(
        input logic [PACKET_WIDTH-1:0] packet,
        input logic [2:0]              idx
    );
        logic [PACKET_WIDTH-1:0] shifted;
        shifted = packet << (WORD_BITS * int'(idx));
        return shifted[PACKET_WIDTH-1 -: WORD_BITS];
    endfunction

endpackage

// File: rtl/packet_storer.sv
// packet_storer
//   Writes one packet to memory as WORD_COUNT consecutive 32-bit words
//   (MSB word first, address OPADDR + addr + 4*i) and returns a done token
//   echoing the request address.
//
//   Build option: PACKET_STORER_WRITE_ACK_EN
//     defined   - each write waits for MEM_RECEIVE_VALID before the next word.
//     undefined - writes are fire-and-forget; MEM_RECEIVE_* is ignored.
//
//   Ports
//     CLK, RST_N                         clock, async active-low reset
//     OPADDR                             packet region base (stable while busy)
//     RECEIVE_SR_VALID/READY/ADDR/PACKET store request
//     MEM_SEND_ADDR_VALID/DATA_VALID     write request valid (always equal)
//     MEM_SEND_ADDR/DATA, MEM_SEND_READY write request payload / accept
//     MEM_RECEIVE_VALID/DATA/READY       write acknowledge (data unused)
//     SEND_DONE_VALID/READY/ADDR         completion token
//
//   state      | meaning
//   S_RECEIVE  | idle, offering RECEIVE_SR_READY
//   S_MEM_SEND | presenting word idx to the memory controller
//   S_MEM_ACK  | waiting for the write acknowledge of word idx
//   S_DONE     | presenting the done token
module packet_storer #(
    parameter int PACKET_WIDTH = packet_storer_pkg::PACKET_WIDTH
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [31:0]             OPADDR,
    input  logic                    RECEIVE_SR_VALID,
    output logic                    RECEIVE_SR_READY,
    input  logic [31:0]             RECEIVE_SR_ADDR,
    input  logic [PACKET_WIDTH-1:0] RECEIVE_SR_PACKET,
    output logic                    MEM_SEND_ADDR_VALID,
    output logic                    MEM_SEND_DATA_VALID,
    output logic [31:0]             MEM_SEND_ADDR,
    output logic [31:0]             MEM_SEND_DATA,
    input  logic                    MEM_SEND_READY,
    input  logic                    MEM_RECEIVE_VALID,
    input  logic [31:0]             MEM_RECEIVE_DATA,
    output logic                    MEM_RECEIVE_READY,
    output logic                    SEND_DONE_VALID,
    input  logic                    SEND_DONE_READY,
    output logic [31:0]             SEND_DONE_ADDR
);
    import packet_storer_pkg::*;

    localparam int WORD_COUNT = PACKET_WIDTH / WORD_BITS;

    state_e                  state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    logic [31:0]             addr_q, addr_d;
    logic [PACKET_WIDTH-1:0] packet_q, packet_d;
    logic                    sr_ready_q, sr_ready_d;
    logic                    mem_valid_q, mem_valid_d;
    logic                    done_valid_q, done_valid_d;

    logic                    sr_hs, mem_hs, done_hs, last_word;
    logic [PACKET_WIDTH-1:0] packet_shifted;

    // Acknowledge data carries nothing for a write.
    logic unused_mem_rx;
    assign unused_mem_rx = ^{MEM_RECEIVE_VALID, MEM_RECEIVE_DATA};

    assign sr_hs     = sr_ready_q & RECEIVE_SR_VALID;
    assign mem_hs    = mem_valid_q & MEM_SEND_READY;
    assign done_hs   = done_valid_q & SEND_DONE_READY;
    assign last_word = (idx_q == 3'(WORD_COUNT - 1));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        packet_d     = packet_q;
        sr_ready_d   = 1'b0;
        mem_valid_d  = 1'b0;
        done_valid_d = 1'b0;
        // Each registered valid/ready is derived from the current state, so it
        // rises one cycle after entry and drops on the handshake edge.
        case (state_q)
            S_RECEIVE: begin
                sr_ready_d = ~sr_hs;
                if (sr_hs) begin
                    addr_d   = RECEIVE_SR_ADDR;
                    packet_d = RECEIVE_SR_PACKET;
                    idx_d    = 3'd0;
                    state_d  = S_MEM_SEND;
                end
            end
            S_MEM_SEND: begin
                mem_valid_d = ~mem_hs;
                if (mem_hs) begin
`ifdef PACKET_STORER_WRITE_ACK_EN
                    state_d = S_MEM_ACK;
`else
                    if (last_word) state_d = S_DONE;
                    else           idx_d   = idx_q + 3'd1;
`endif
                end
            end
`ifdef PACKET_STORER_WRITE_ACK_EN
            S_MEM_ACK: begin
                if (MEM_RECEIVE_VALID) begin
                    if (last_word) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_MEM_SEND;
                    end
                end
            end
`endif
            S_DONE: begin
                done_valid_d = ~done_hs;
                if (done_hs) state_d = S_RECEIVE;
            end
            default: state_d = S_RECEIVE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_RECEIVE;
            idx_q        <= 3'd0;
            addr_q       <= '0;
            packet_q     <= '0;
            sr_ready_q   <= 1'b0;
            mem_valid_q  <= 1'b0;
            done_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            packet_q     <= packet_d;
            sr_ready_q   <= sr_ready_d;
            mem_valid_q  <= mem_valid_d;
            done_valid_q <= done_valid_d;
        end
    end

    // Address and data follow idx_q, so both stay stable through a stall.
    assign packet_shifted = packet_q << (WORD_BITS * int'(idx_q));

    assign RECEIVE_SR_READY    = sr_ready_q;
    assign MEM_SEND_ADDR_VALID = mem_valid_q;
    assign MEM_SEND_DATA_VALID = mem_valid_q;
    assign MEM_SEND_ADDR       = OPADDR + addr_q + (32'(WORD_SIZE_BYTES) * {29'd0, idx_q});
    assign MEM_SEND_DATA       = packet_shifted[PACKET_WIDTH-1 -: WORD_BITS];
    assign MEM_RECEIVE_READY   = 1'b1;
    assign SEND_DONE_VALID     = done_valid_q;
    assign SEND_DONE_ADDR      = addr_q;

endmodule

// File: tb/tb_packet_storer.sv
module tb_packet_storer;
`ifdef PACKET_STORER_WRITE_ACK_EN
    localparam bit ACK_EN  = 1'b1;
    localparam int EXP_LAT = 16;
`else
    localparam bit ACK_EN  = 1'b0;
    localparam int EXP_LAT = 11;
`endif

    logic         CLK, RST_N;
    logic [31:0]  OPADDR;
    logic         RECEIVE_SR_VALID, RECEIVE_SR_READY;
    logic [31:0]  RECEIVE_SR_ADDR;
    logic [159:0] RECEIVE_SR_PACKET;
    logic         MEM_SEND_ADDR_VALID, MEM_SEND_DATA_VALID;
    logic [31:0]  MEM_SEND_ADDR, MEM_SEND_DATA;
    logic         MEM_SEND_READY;
    logic         MEM_RECEIVE_VALID;
    logic [31:0]  MEM_RECEIVE_DATA;
    logic         MEM_RECEIVE_READY;
    logic         SEND_DONE_VALID, SEND_DONE_READY;
    logic [31:0]  SEND_DONE_ADDR;

    logic spur_ack, model_ack;
    assign MEM_RECEIVE_VALID = spur_ack | model_ack;

    packet_storer #(.PACKET_WIDTH(160)) dut (
        .CLK(CLK), .RST_N(RST_N), .OPADDR(OPADDR),
        .RECEIVE_SR_VALID(RECEIVE_SR_VALID), .RECEIVE_SR_READY(RECEIVE_SR_READY),
        .RECEIVE_SR_ADDR(RECEIVE_SR_ADDR), .RECEIVE_SR_PACKET(RECEIVE_SR_PACKET),
        .MEM_SEND_ADDR_VALID(MEM_SEND_ADDR_VALID), .MEM_SEND_DATA_VALID(MEM_SEND_DATA_VALID),
        .MEM_SEND_ADDR(MEM_SEND_ADDR), .MEM_SEND_DATA(MEM_SEND_DATA),
        .MEM_SEND_READY(MEM_SEND_READY),
        .MEM_RECEIVE_VALID(MEM_RECEIVE_VALID), .MEM_RECEIVE_DATA(MEM_RECEIVE_DATA),
        .MEM_RECEIVE_READY(MEM_RECEIVE_READY),
        .SEND_DONE_VALID(SEND_DONE_VALID), .SEND_DONE_READY(SEND_DONE_READY),
        .SEND_DONE_ADDR(SEND_DONE_ADDR)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_done[$];

    int checks = 0, errors = 0;
    int cyc = 0;
    int wr_count = 0, wr_in_pkt = 0, done_count = 0, sr_hs_count = 0, hs_edge = 0;
    int stall_word = 0, stall_left = 0, done_hold = 0;
    bit lat_check = 0, stall_started = 0, done_seen = 0, ack_pending = 0;
    logic [31:0] held_addr, held_data;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Monitor / memory model: drives readies and acks, pops and compares.
    initial begin
        wr_t e;
        model_ack       = 1'b0;
        MEM_SEND_READY  = 1'b1;
        SEND_DONE_READY = 1'b1;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                model_ack       = 1'b0;
                ack_pending     = 1'b0;
                MEM_SEND_READY  = 1'b1;
                SEND_DONE_READY = 1'b1;
                stall_started   = 1'b0;
                done_seen       = 1'b0;
            end else begin
                model_ack   = ack_pending;
                ack_pending = 1'b0;
                if (MEM_SEND_ADDR_VALID || MEM_SEND_DATA_VALID)
                    chk("valid_pair", 32'(MEM_SEND_DATA_VALID), 32'(MEM_SEND_ADDR_VALID));
                if (stall_started && !MEM_SEND_ADDR_VALID)
                    chk("stall_valid_held", 32'(MEM_SEND_ADDR_VALID), 32'd1);
                if (MEM_SEND_ADDR_VALID && stall_left > 0 && wr_in_pkt == stall_word) begin
                    MEM_SEND_READY = 1'b0;
                    if (!stall_started) begin
                        held_addr     = MEM_SEND_ADDR;
                        held_data     = MEM_SEND_DATA;
                        stall_started = 1'b1;
                    end else begin
                        chk("stall_addr", MEM_SEND_ADDR, held_addr);
                        chk("stall_data", MEM_SEND_DATA, held_data);
                    end
                    stall_left--;
                end else begin
                    MEM_SEND_READY = 1'b1;
                end
                if (MEM_SEND_ADDR_VALID && MEM_SEND_READY) begin
                    stall_started = 1'b0;
                    if (exp_wr.size() == 0) begin
                        chk("unexpected_write", MEM_SEND_ADDR, 32'hDEAD_DEAD);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("write_addr", MEM_SEND_ADDR, e.addr);
                        chk("write_data", MEM_SEND_DATA, e.data);
                    end
                    wr_count++;
                    wr_in_pkt++;
                    ack_pending = ACK_EN;
                end
                if (SEND_DONE_VALID) begin
                    if (!done_seen && lat_check)
                        chk("done_latency", 32'(cyc - hs_edge), 32'(EXP_LAT));
                    done_seen = 1'b1;
                    if (done_hold > 0) begin
                        SEND_DONE_READY = 1'b0;
                        done_hold--;
                        chk("sr_ready_while_done", 32'(RECEIVE_SR_READY), 32'd0);
                    end else begin
                        SEND_DONE_READY = 1'b1;
                        if (exp_done.size() == 0) begin
                            chk("unexpected_done", SEND_DONE_ADDR, 32'hDEAD_DEAD);
                        end else begin
                            chk("done_addr", SEND_DONE_ADDR, exp_done.pop_front());
                        end
                        done_count++;
                        done_seen = 1'b0;
                    end
                end else begin
                    SEND_DONE_READY = 1'b1;
                end
                if (RECEIVE_SR_VALID && RECEIVE_SR_READY) begin
                    hs_edge = cyc + 1;
                    sr_hs_count++;
                    wr_in_pkt = 0;
                end
            end
        end
    end

    task automatic start_req(input logic [31:0] opaddr, input logic [31:0] addr,
                             input logic [159:0] pkt, input int sw, input int sc,
                             input int dh, input bit latc);
        int n;
        bit ok;
        OPADDR     = opaddr;
        stall_word = sw;
        stall_left = sc;
        done_hold  = dh;
        lat_check  = latc;
        for (int i = 0; i < 5; i++)
            exp_wr.push_back(wr_t'{addr: opaddr + addr + 32'(4 * i),
                                   data: 32'(pkt >> (32 * (4 - i)))});
        exp_done.push_back(addr);
        n  = sr_hs_count;
        ok = 1'b0;
        RECEIVE_SR_ADDR   = addr;
        RECEIVE_SR_PACKET = pkt;
        RECEIVE_SR_VALID  = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(posedge CLK); #1;
            if (sr_hs_count != n) ok = 1'b1;
        end
        RECEIVE_SR_VALID = 1'b0;
        if (!ok) fail_now("sr_handshake");
    endtask

    task automatic wait_done(input int start);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(posedge CLK); #1;
            if (done_count != start) ok = 1'b1;
        end
        if (!ok) fail_now("done_wait");
    endtask

    task automatic run_pkt(input logic [31:0] opaddr, input logic [31:0] addr,
                           input logic [159:0] pkt, input int sw, input int sc,
                           input int dh, input bit latc);
        int start;
        start = done_count;
        start_req(opaddr, addr, pkt, sw, sc, dh, latc);
        wait_done(start);
    endtask

    initial begin
        repeat (20000) @(posedge CLK);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, dc;
        bit ok;
        RST_N             = 1'b0;
        OPADDR            = '0;
        RECEIVE_SR_VALID  = 1'b0;
        RECEIVE_SR_ADDR   = '0;
        RECEIVE_SR_PACKET = '0;
        MEM_RECEIVE_DATA  = 32'h5555_5555;
        spur_ack          = 1'b0;
        repeat (3) @(posedge CLK); #1;
        chk("rst_sr_ready",   32'(RECEIVE_SR_READY),    32'd0);
        chk("rst_addr_valid", 32'(MEM_SEND_ADDR_VALID), 32'd0);
        chk("rst_data_valid", 32'(MEM_SEND_DATA_VALID), 32'd0);
        chk("rst_done_valid", 32'(SEND_DONE_VALID),     32'd0);
        chk("rst_rx_ready",   32'(MEM_RECEIVE_READY),   32'd1);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        chk("sr_ready_after_release", 32'(RECEIVE_SR_READY), 32'd1);

        // Basic packet, zero-wait memory
        run_pkt(32'h0000_1000, 32'h20,
                {32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4}, 0, 0, 0, 1'b1);
        // Stall word 2 for 4 cycles
        run_pkt(32'h0000_2000, 32'h100,
                {32'hB0B0_0000, 32'hB1B1_1111, 32'hB2B2_2222, 32'hB3B3_3333, 32'hB4B4_4444},
                2, 4, 0, 1'b0);
        // Done held off for 5 cycles
        run_pkt(32'h0001_0000, 32'h0000_0044,
                {32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4}, 0, 0, 5, 1'b1);
        // Address wrap
        run_pkt(32'hFFFF_FFF8, 32'h0,
                {32'hD000_0001, 32'hD000_0002, 32'hD000_0003, 32'hD000_0004, 32'hD000_0005},
                0, 0, 0, 1'b1);

        // Spurious ack while idle
        @(posedge CLK); #1;
        spur_ack = 1'b1;
        @(posedge CLK); #1;
        spur_ack = 1'b0;
        chk("spur_sr_ready",   32'(RECEIVE_SR_READY),    32'd1);
        chk("spur_addr_valid", 32'(MEM_SEND_ADDR_VALID), 32'd0);
        chk("spur_done_valid", 32'(SEND_DONE_VALID),     32'd0);

        // Reset after word 3 accepted
        base = wr_count;
        dc   = done_count;
        start_req(32'h0000_3000, 32'h40,
                  {32'hE0, 32'hE1, 32'hE2, 32'hE3, 32'hE4}, 0, 0, 0, 1'b0);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            if (wr_count >= base + 4) ok = 1'b1;
            else begin @(posedge CLK); #1; end
        end
        if (!ok) fail_now("word3_accept");
        RST_N = 1'b0;
        #1;
        chk("midrst_sr_ready",   32'(RECEIVE_SR_READY),    32'd0);
        chk("midrst_addr_valid", 32'(MEM_SEND_ADDR_VALID), 32'd0);
        chk("midrst_data_valid", 32'(MEM_SEND_DATA_VALID), 32'd0);
        chk("midrst_done_valid", 32'(SEND_DONE_VALID),     32'd0);
        chk("midrst_done_addr",  SEND_DONE_ADDR,           32'd0);
        chk("midrst_rx_ready",   32'(MEM_RECEIVE_READY),   32'd1);
        exp_wr.delete();
        exp_done.delete();
        repeat (2) @(posedge CLK); #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        chk("midrst_no_done", 32'(done_count), 32'(dc));

        // Restart from word 0
        run_pkt(32'h0000_4000, 32'h8,
                {32'hF0, 32'hF1, 32'hF2, 32'hF3, 32'hF4}, 0, 0, 0, 1'b1);

        repeat (3) @(posedge CLK); #1;
        chk("left_writes", 32'(exp_wr.size()),   32'd0);
        chk("left_done",   32'(exp_done.size()), 32'd0);
        chk("total_writes", 32'(wr_count),  32'd29);
        chk("total_done",   32'(done_count), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
